// File: rtl/aes128_encrypt_iter.sv
// rtl/aes128_encrypt_iter.sv - iterative AES-128 encrypt core, one round per clock (optional AES_COMPLEMENTARY_OUT_EN)

// AES S-box: multiplicative inverse in GF(2^8) as x^254, then the affine transform
module aes128_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);

  function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] z);
    logic [7:0] p;
    logic [7:0] acc;
    p   = 8'h00;
    acc = x;
    for (int i = 0; i < 8; i++) begin
      if (z[i]) p = p ^ acc;
      acc = {acc[6:0], 1'b0} ^ (acc[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, x252, inv;

  // addition chain for x^254; zero maps to zero without special casing
  assign x2   = gf_mul(a, a);
  assign x3   = gf_mul(x2, a);
  assign x6   = gf_mul(x3, x3);
  assign x12  = gf_mul(x6, x6);
  assign x15  = gf_mul(x12, x3);
  assign x30  = gf_mul(x15, x15);
  assign x60  = gf_mul(x30, x30);
  assign x120 = gf_mul(x60, x60);
  assign x240 = gf_mul(x120, x120);
  assign x252 = gf_mul(x240, x12);
  assign inv  = gf_mul(x252, x2);

  assign y = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
             {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;

endmodule

module aes128_encrypt_iter (
  input  logic         AES_clk,
  input  logic         AES_rst,
  input  logic         AES_en,
  input  logic [127:0] AES_data_in,
  input  logic [127:0] AES_key_in,
  output logic [127:0] AES_data_out,
  output logic         AES_data_out_valid
`ifdef AES_COMPLEMENTARY_OUT_EN
  ,output logic [127:0] AES_data_out_complementary
  ,output logic         AES_data_out_complementary_valid
`endif
);

  typedef enum logic {IDLE, RUN} fsm_t;

  fsm_t         fsm_q;
  logic [127:0] state_q;
  logic [127:0] rkey_q;
  logic [3:0]   round_q;

  logic [7:0]   sb_out [16];
  logic [7:0]   sr     [16];
  logic [7:0]   mc     [16];
  logic [31:0]  rot_w;
  logic [31:0]  sub_w;
  logic [31:0]  temp_w;
  logic [7:0]   rcon;
  logic [127:0] next_rkey;
  logic [127:0] round_out;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // SubBytes on all 16 state bytes; byte n lives at bits [127-8n -: 8]
  for (genvar n = 0; n < 16; n++) begin : g_state_sbox
    aes128_sbox u_sbox (.a(state_q[127-8*n -: 8]), .y(sb_out[n]));
  end

  // ShiftRows: row r rotates left by r columns (byte n is row n%4, column n/4)
  always_comb begin
    for (int n = 0; n < 16; n++) sr[n] = sb_out[(n % 4) + 4 * (((n / 4) + (n % 4)) % 4)];
  end

  // MixColumns on each column
  always_comb begin
    for (int c = 0; c < 4; c++) begin
      mc[4*c]   = xtime(sr[4*c]) ^ xtime(sr[4*c+1]) ^ sr[4*c+1] ^ sr[4*c+2] ^ sr[4*c+3];
      mc[4*c+1] = sr[4*c] ^ xtime(sr[4*c+1]) ^ xtime(sr[4*c+2]) ^ sr[4*c+2] ^ sr[4*c+3];
      mc[4*c+2] = sr[4*c] ^ sr[4*c+1] ^ xtime(sr[4*c+2]) ^ xtime(sr[4*c+3]) ^ sr[4*c+3];
      mc[4*c+3] = xtime(sr[4*c]) ^ sr[4*c] ^ sr[4*c+1] ^ sr[4*c+2] ^ xtime(sr[4*c+3]);
    end
  end

  // round constant for the round currently being computed
  always_comb begin
    case (round_q)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  end

  // key schedule: RotWord then SubWord on the last word of the previous round key
  assign rot_w = {rkey_q[23:0], rkey_q[31:24]};

  for (genvar j = 0; j < 4; j++) begin : g_key_sbox
    aes128_sbox u_sbox (.a(rot_w[31-8*j -: 8]), .y(sub_w[31-8*j -: 8]));
  end

  assign temp_w            = sub_w ^ {rcon, 24'h000000};
  assign next_rkey[127:96] = rkey_q[127:96] ^ temp_w;
  assign next_rkey[95:64]  = rkey_q[95:64]  ^ next_rkey[127:96];
  assign next_rkey[63:32]  = rkey_q[63:32]  ^ next_rkey[95:64];
  assign next_rkey[31:0]   = rkey_q[31:0]   ^ next_rkey[63:32];

  // AddRoundKey; the final round skips MixColumns
  always_comb begin
    round_out = '0;
    for (int n = 0; n < 16; n++) begin
      round_out[127-8*n -: 8] = ((round_q == 4'd10) ? sr[n] : mc[n]) ^ next_rkey[127-8*n -: 8];
    end
  end

  // control FSM: capture in IDLE, one round per edge in RUN, registered result and pulse
  always_ff @(posedge AES_clk) begin
    if (AES_rst) begin
      fsm_q              <= IDLE;
      round_q            <= 4'd0;
      state_q            <= '0;
      rkey_q             <= '0;
      AES_data_out       <= '0;
      AES_data_out_valid <= 1'b0;
`ifdef AES_COMPLEMENTARY_OUT_EN
      AES_data_out_complementary       <= '1;
      AES_data_out_complementary_valid <= 1'b0;
`endif
    end else begin
      AES_data_out_valid <= 1'b0;
`ifdef AES_COMPLEMENTARY_OUT_EN
      AES_data_out_complementary_valid <= 1'b0;
`endif
      case (fsm_q)
        IDLE: begin
          if (AES_en) begin
            state_q <= AES_data_in ^ AES_key_in;
            rkey_q  <= AES_key_in;
            round_q <= 4'd1;
            fsm_q   <= RUN;
          end
        end
        RUN: begin
          state_q <= round_out;
          rkey_q  <= next_rkey;
          if (round_q == 4'd10) begin
            AES_data_out       <= round_out;
            AES_data_out_valid <= 1'b1;
`ifdef AES_COMPLEMENTARY_OUT_EN
            AES_data_out_complementary       <= ~round_out;
            AES_data_out_complementary_valid <= 1'b1;
`endif
            round_q <= 4'd0;
            fsm_q   <= IDLE;
          end else begin
            round_q <= round_q + 4'd1;
          end
        end
        default: fsm_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes128_encrypt_iter.sv
// tb/tb_aes128_encrypt_iter.sv - self-checking bench for aes128_encrypt_iter against a reference AES model

module tb_aes128_encrypt_iter;

  logic         clk = 1'b0;
  logic         rst;
  logic         en;
  logic [127:0] din;
  logic [127:0] key;
  logic [127:0] dout;
  logic         dvalid;
`ifdef AES_COMPLEMENTARY_OUT_EN
  logic [127:0] dout_c;
  logic         dvalid_c;
`endif

  int tests = 0;
  int fails = 0;

  logic [7:0] sbox_t [256];

  typedef struct {
    logic [127:0] key;
    logic [127:0] pt;
    logic [127:0] ct;
  } vec_t;

  vec_t vecs [3];

  aes128_encrypt_iter dut (
    .AES_clk(clk),
    .AES_rst(rst),
    .AES_en(en),
    .AES_data_in(din),
    .AES_key_in(key),
    .AES_data_out(dout),
    .AES_data_out_valid(dvalid)
`ifdef AES_COMPLEMENTARY_OUT_EN
    ,.AES_data_out_complementary(dout_c)
    ,.AES_data_out_complementary_valid(dvalid_c)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // S-box built by walking the multiplicative group with generator 3 and its inverse
  task automatic build_sbox();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b00};
      q = q ^ {q[3:0], 4'h0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
      sbox_t[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sbox_t[0] = 8'h63;
  endtask

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // whole-block AES-128: expand all 44 key words first, then run the ten rounds on a byte array
  function automatic logic [127:0] ref_aes(input logic [127:0] k, input logic [127:0] pt);
    logic [31:0]  w [44];
    logic [7:0]   st [16];
    logic [7:0]   tmp [16];
    logic [31:0]  t;
    logic [7:0]   rc;
    logic [127:0] res;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]} ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int n = 0; n < 16; n++) st[n] = pt[127-8*n -: 8] ^ w[n/4][31-8*(n%4) -: 8];
    for (int r = 1; r <= 10; r++) begin
      for (int n = 0; n < 16; n++) st[n] = sbox_t[st[n]];
      for (int n = 0; n < 16; n++) tmp[n] = st[(n%4) + 4*(((n/4) + (n%4)) % 4)];
      for (int c = 0; c < 4; c++) begin
        if (r < 10) begin
          st[4*c]   = xt(tmp[4*c]) ^ xt(tmp[4*c+1]) ^ tmp[4*c+1] ^ tmp[4*c+2] ^ tmp[4*c+3];
          st[4*c+1] = tmp[4*c] ^ xt(tmp[4*c+1]) ^ xt(tmp[4*c+2]) ^ tmp[4*c+2] ^ tmp[4*c+3];
          st[4*c+2] = tmp[4*c] ^ tmp[4*c+1] ^ xt(tmp[4*c+2]) ^ xt(tmp[4*c+3]) ^ tmp[4*c+3];
          st[4*c+3] = xt(tmp[4*c]) ^ tmp[4*c] ^ tmp[4*c+1] ^ tmp[4*c+2] ^ xt(tmp[4*c+3]);
        end else begin
          for (int m = 0; m < 4; m++) st[4*c+m] = tmp[4*c+m];
        end
      end
      for (int n = 0; n < 16; n++) st[n] = st[n] ^ w[4*r + n/4][31-8*(n%4) -: 8];
    end
    for (int n = 0; n < 16; n++) res[127-8*n -: 8] = st[n];
    return res;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // single-cycle start, then wait (bounded) for the valid pulse; lat = edges after capture, -1 on timeout
  task automatic run_block(input logic [127:0] k, input logic [127:0] pt,
                           output logic [127:0] ct, output int lat);
    key = k;
    din = pt;
    en  = 1'b1;
    tick();
    en  = 1'b0;
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (dvalid) begin
        lat = i;
        break;
      end
    end
    ct = dout;
  endtask

  initial begin
    logic [127:0] ct, k, p, exp, prev;
    int lat, pulses, vcount;
    int pulse_at [8];

    build_sbox();
    vecs[0] = '{128'h000102030405060708090a0b0c0d0e0f, 128'h00112233445566778899aabbccddeeff,
                128'h69c4e0d86a7b0430d8cdb78070b4c55a};
    vecs[1] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h3243f6a8885a308d313198a2e0370734,
                128'h3925841d02dc09fbdc118597196a0b32};
    vecs[2] = '{128'h0, 128'h0, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e};

    rst = 1'b1;
    en  = 1'b0;
    din = '0;
    key = '0;
    tick();
    tick();
    check("reset_data", dout, 128'h0);
    check("reset_valid", {127'h0, dvalid}, 128'h0);
    rst = 1'b0;
    tick();

    // known-answer vectors: model sanity, latency, ciphertext, single-cycle pulse
    for (int i = 0; i < 3; i++) begin
      check($sformatf("model_kat%0d", i), ref_aes(vecs[i].key, vecs[i].pt), vecs[i].ct);
      run_block(vecs[i].key, vecs[i].pt, ct, lat);
      check($sformatf("kat%0d_latency", i), 128'(lat), 128'd10);
      check($sformatf("kat%0d_data", i), ct, vecs[i].ct);
      tick();
      check($sformatf("kat%0d_pulse_width", i), {127'h0, dvalid}, 128'h0);
    end

    // random blocks against the reference model
    for (int i = 0; i < 6; i++) begin
      k = rand128();
      p = rand128();
      run_block(k, p, ct, lat);
      check($sformatf("rand%0d_latency", i), 128'(lat), 128'd10);
      check($sformatf("rand%0d_data", i), ct, ref_aes(k, p));
      tick();
    end

    // AES_en held for 51 edges, then dropped while data_in churns
    k   = 128'haa2bdb40bff6a5e8caa9ba3ebc1e2acc;
    p   = 128'h000000f6000000000000000000000000;
    exp = ref_aes(k, p);
    key = k;
    din = p;
    en  = 1'b1;
    pulses = 0;
    for (int i = 1; i <= 81; i++) begin
      if (i > 51) begin
        en  = 1'b0;
        din = rand128();
      end
      tick();
      if (dvalid) begin
        if (pulses < 8) pulse_at[pulses] = i;
        pulses++;
        check($sformatf("hold_data_pulse%0d", pulses), dout, exp);
      end
    end
    check("hold_pulse_count", 128'(pulses), 128'd5);
    for (int j = 0; j < 5 && j < pulses; j++)
      check($sformatf("hold_pulse%0d_edge", j), 128'(pulse_at[j]), 128'(11 * (j + 1)));
    check("hold_data_kept", dout, exp);

    // inputs change during RUN; result must come from the captured values
    k = rand128();
    p = rand128();
    key = k;
    din = p;
    en  = 1'b1;
    tick();
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      en  = (i < 8) ? 1'($urandom_range(0, 1)) : 1'b0;
      din = rand128();
      key = rand128();
      tick();
      if (dvalid) begin
        lat = i;
        break;
      end
    end
    check("run_change_latency", 128'(lat), 128'd10);
    check("run_change_data", dout, ref_aes(k, p));
    en = 1'b0;
    tick();

    // reset in the middle of round 5 aborts the operation
    prev = dout;
    key  = rand128();
    din  = rand128();
    en   = 1'b1;
    tick();
    en = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrun_reset_data", dout, 128'h0);
    check("midrun_reset_valid", {127'h0, dvalid}, 128'h0);
    check("midrun_prev_nonzero", 128'(prev != 128'h0), 128'd1);
    vcount = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (dvalid) vcount++;
    end
    check("midrun_no_pulse", 128'(vcount), 128'd0);
    check("midrun_data_held", dout, 128'h0);
    run_block(vecs[1].key, vecs[1].pt, ct, lat);
    check("after_reset_latency", 128'(lat), 128'd10);
    check("after_reset_data", ct, vecs[1].ct);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
